factorial_engine: RTL and testbench

Parametrised multi-mode product engine. It accepts an operand pair over a valid/ready handshake and iteratively computes one of three results: n!, n!! or the falling factorial n!/(n−k)!. It saturates with an overflow flag when the result exceeds OUT_W bits, and holds the result under output backpressure. It is the next-generation replacement for the fixed 8/16-bit factorial unit and is used wherever the datapath needs combinatorial counts.

---
 rtl/factorial_pkg.sv | 27 ++
 rtl/factorial_mul_sat.sv | 23 ++
 rtl/factorial_engine.sv | 121 ++++++++++++
 tb/tb_factorial_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
// Shared types for the multi-mode product engine: operation modes and FSM states.
package factorial_pkg;

    typedef enum logic [1:0] {
        MODE_FACT  = 2'd0,
        MODE_DFACT = 2'd1,
        MODE_FALL  = 2'd2
    } fact_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fact_state_t;

    // The unused encoding 3 behaves as a plain factorial request.
    function automatic fact_mode_t normalize_mode(input logic [1:0] raw);
        fact_mode_t m;
        case (raw)
            2'd1:    m = MODE_DFACT;
            2'd2:    m = MODE_FALL;
            default: m = MODE_FACT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/factorial_mul_sat.sv
// Widening acc x mult multiply with saturation to all ones when the product
// does not fit in OUT_W bits.
module factorial_mul_sat
    import factorial_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  mult,
    output logic [OUT_W-1:0] acc_next,
    output logic             ovf
);

    localparam int unsigned PROD_W = OUT_W + IN_W;

    logic [PROD_W-1:0] prod;

    assign prod     = PROD_W'(acc) * PROD_W'(mult);
    assign ovf      = |prod[PROD_W-1:OUT_W];
    assign acc_next = ovf ? {OUT_W{1'b1}} : prod[OUT_W-1:0];

endmodule

// File: rtl/factorial_engine.sv
// Iterative n!, n!! and n!/(n-k)! engine with saturating overflow and a
// valid/ready request and result handshake.
module factorial_engine
    import factorial_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_n,
    input  logic [IN_W-1:0]  in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    fact_state_t      state_q, state_d;
    fact_mode_t       mode_q, mode_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IN_W-1:0]  mult_q, mult_d;
    logic [IN_W-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [OUT_W-1:0] mul_acc;
    logic             mul_ovf;

    factorial_mul_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mul_sat (
        .acc      (acc_q),
        .mult     (mult_q),
        .acc_next (mul_acc),
        .ovf      (mul_ovf)
    );

    // Reset is folded in so no request can be taken while it is asserted.
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_FACT;
            acc_q   <= '0;
            mult_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            mult_q  <= mult_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        mult_d  = mult_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    acc_d   = OUT_W'(1);
                    mult_d  = in_n;
                    cnt_d   = in_k;
                    mode_d  = normalize_mode(in_mode);
                    ovf_d   = 1'b0;
                    state_d = CALC;
                end
            end

            CALC: begin
                if ((mode_q != MODE_FALL) && (mult_q <= IN_W'(1))) begin
                    state_d = DONE;
                end else if ((mode_q == MODE_FALL) && (cnt_q == '0)) begin
                    state_d = DONE;
                end else if ((mode_q == MODE_FALL) && (mult_q == '0)) begin
                    // k > n: a zero factor entered the product.
                    acc_d   = '0;
                    state_d = DONE;
                end else if (mul_ovf) begin
                    acc_d   = mul_acc;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d  = mul_acc;
                    mult_d = (mode_q == MODE_DFACT) ? (mult_q - IN_W'(2))
                                                    : (mult_q - IN_W'(1));
                    if (mode_q == MODE_FALL) begin
                        cnt_d = cnt_q - IN_W'(1);
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_factorial_engine.sv
// Scoreboard bench for factorial_engine: expected results are queued when a
// request is driven and compared when the result handshake completes.
module tb_factorial_engine;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 32;
    localparam int          WAIT_MAX = 300;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             ovf;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_mode = 2'd0;
    logic [IN_W-1:0]  in_n = '0;
    logic [IN_W-1:0]  in_k = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    factorial_engine #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_n      (in_n),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge and hold it across the accepting edge.
    task automatic drive(input logic [1:0] mode, input int n, input int k,
                         input logic [OUT_W-1:0] ed, input logic eo, input int el);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < WAIT_MAX) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_mode  = mode;
        in_n     = IN_W'(n);
        in_k     = IN_W'(k);
        e.data = ed;
        e.ovf  = eo;
        e.lat  = el;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid, optionally stall for hold cycles, then consume.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < WAIT_MAX);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, 64'(out_data), 64'(e.data));
            check({tag, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
            check({tag, "_lat"}, 64'(lat), 64'(e.lat));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = (i % 2 == 0);
                in_n     = IN_W'(3);
                in_mode  = 2'd0;
                check({tag, "_hold_data"}, 64'(out_data), 64'(e.data));
                check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(2'd0, 5, 0, 32'd120, 1'b0, 5);          collect("fact5", 0);
        drive(2'd0, 0, 0, 32'd1, 1'b0, 1);            collect("fact0", 0);
        drive(2'd0, 12, 0, 32'd479001600, 1'b0, 12);  collect("fact12", 0);
        drive(2'd0, 13, 0, 32'hFFFF_FFFF, 1'b1, 12);  collect("fact13", 0);
        drive(2'd1, 7, 0, 32'd105, 1'b0, 4);          collect("dfact7", 0);
        drive(2'd1, 8, 0, 32'd384, 1'b0, 5);          collect("dfact8", 0);
        drive(2'd1, 1, 0, 32'd1, 1'b0, 1);            collect("dfact1", 0);
        drive(2'd2, 10, 3, 32'd720, 1'b0, 4);         collect("fall10_3", 0);
        drive(2'd2, 10, 0, 32'd1, 1'b0, 1);           collect("fall10_0", 0);
        drive(2'd2, 3, 5, 32'd0, 1'b0, 4);            collect("fall3_5", 0);
        drive(2'd2, 5, 5, 32'd120, 1'b0, 6);          collect("fall5_5", 0);
        drive(2'd2, 0, 2, 32'd0, 1'b0, 1);            collect("fall0_2", 0);
        drive(2'd3, 4, 9, 32'd24, 1'b0, 4);           collect("mode3_4", 0);

        // Stall the result for 10 cycles while requests are pulsed.
        drive(2'd0, 6, 0, 32'd720, 1'b0, 6);          collect("bp6", 10);
        @(negedge clk);
        check("bp_no_accept", 64'(out_valid), 64'd0);
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        drive(2'd0, 3, 0, 32'd6, 1'b0, 3);            collect("after_bp", 0);

        // Reset during the third CALC cycle discards the in-flight product.
        drive(2'd0, 10, 0, 32'd3628800, 1'b0, 10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_ovf", 64'(out_ovf), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1 check("post_rst_ready", 64'(in_ready), 64'd1);
        drive(2'd0, 4, 0, 32'd24, 1'b0, 4);           collect("post_rst4", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
